riscv_multicycle_ctrl: RTL and testbench
========================================

Name: riscv_multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the existing datapath (PC, instruction memory, register file, ALU, data memory, sign extender) as FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over several clocks, replacing single-cycle control. It latches the fetched instruction and drives every datapath select and enable. It waits on a memory ready handshake, with a watchdog that traps on a stalled memory. It supports R-type, I-type ALU, LW, SW and BEQ/BNE; any other opcode traps.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting for mem_ready before trap (>=1)
XLEN, 32, instruction/counter width

Ports:
clock  in  1  system clock
rst  in  1  asynchronous reset, active-high
run  in  1  level; leaves IDLE and keeps sequencing while 1
instr  in  32  instruction-memory read data
mem_ready  in  1  memory access completes this cycle
zero  in  1  ALU zero flag
ir_write  out  1  load instruction register
pc_write  out  1  update PC
pc_src  out  1  0=PC+4, 1=branch target (PC+imm)
reg_write  out  1  register-file write enable
wb_sel  out  1  0=ALU result, 1=memory data
mem_read  out  1  data-memory read strobe
mem_write  out  1  data-memory write strobe
alu_src_b  out  1  0=rs2 data, 1=sign-extended imm
alu_op  out  4  ALU control, {funct7[5],funct3} encoding
state_o  out  4  current state, debug
trap  out  1  sticky, set on illegal opcode or timeout
trap_cause  out  2  0=none, 1=illegal, 2=mem timeout
retired  out  XLEN  instructions completed, wraps

Behaviour:
- Reset (async): state=IDLE, IR=0, all strobes/selects 0, alu_op=0, trap=0, trap_cause=0, retired=0, wait counter=0.
- Outputs are Moore-decoded from the state register and the latched IR; no instr-to-output combinational path.
- States: IDLE, FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB, BRANCH, TRAP.
- IDLE: if run=1 then FETCH.
- FETCH: on mem_ready=1, ir_write=1 and the cycle goes to DECODE. While mem_ready=0, stay and increment the wait counter.
- DECODE: opcode=IR[6:0]. 0110011/0010011/0000011/0100011 go to EXEC. 1100011 with funct3 000 or 001 goes to BRANCH. Anything else goes to TRAP with cause 1.
- EXEC: R-type uses alu_src_b=0, alu_op={IR[30],funct3}. I-type uses alu_src_b=1, alu_op={IR[30]&(funct3==101),funct3}. LW/SW use alu_src_b=1, alu_op=ADD. Next state is WB for R/I, MEM_RD for LW, MEM_WR for SW.
- MEM_RD/MEM_WR: hold mem_read/mem_write and alu_op=ADD until mem_ready. In MEM_RD the ready cycle goes to WB. In MEM_WR the ready cycle asserts pc_write (pc_src=0) and retires.
- WB: one cycle with reg_write=1, wb_sel=1 for LW else 0, pc_write=1, pc_src=0, retires.
- BRANCH: one cycle with alu_src_b=0, alu_op=SUB(1000), pc_write=1. pc_src=zero for BEQ, ~zero for BNE. Retires.
- After a retiring state: go to FETCH if run=1, else IDLE.
- Timeout: the wait counter clears on entering FETCH/MEM_RD/MEM_WR. If the counter reaches MEM_TIMEOUT-1 with mem_ready=0, go to TRAP with cause 2. mem_ready=1 on that same cycle wins, so no trap.
- TRAP: all strobes 0. The state is held until rst. If a trap cause is already latched, the first cause is kept.
- rd=x0 writes are still issued; the register file ignores them.
- Reset mid-access drops the strobes immediately (async). No partial retire count.
- retired wraps from 2^XLEN-1 to 0.

Decomposition:
- Package riscv_ctrl_pkg: state enum, opcode constants (OP_R, OP_I, OP_LW, OP_SW, OP_BR), ALU codes (ALU_ADD=0000, ALU_SUB=1000, ALU_SRA=1101, ...), trap cause codes.
- Sub-module riscv_mem_watchdog: wait counter plus timeout compare, with start/ready/timeout ports.
- The FSM and output decode stay in riscv_multicycle_ctrl.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), mem_ready=1 on the first FETCH cycle -> states FETCH,DECODE,EXEC,WB. alu_op=0000, reg_write=1 only in WB. retired goes 0->1.
- LW x5,8(x1) (0x0080A283) with mem_ready delayed 3 cycles in MEM_RD -> mem_read held 4 cycles. WB with wb_sel=1. Total 8 cycles from FETCH.
- BEQ x1,x2,+16 (0x00208863): zero=1 -> pc_src=1; zero=0 -> pc_src=0. pc_write=1 in BRANCH in both cases.
- SRAI x4,x4,2 (0x40225213) -> alu_op=1101, alu_src_b=1. ADDI with IR[30]=1 -> alu_op=0000.
- Opcode 0x7F -> TRAP, trap_cause=1, strobes 0. Stays in TRAP until rst, and rst clears to IDLE.
- SW with mem_ready held 0 and MEM_TIMEOUT=4 -> TRAP after 4 MEM_WR cycles, cause 2. A repeat run with ready on cycle 4 gives no trap.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control slice.
// Contents: FSM state encoding, opcode and funct3 constants, ALU control
// codes, trap cause codes, and decode helpers for the EXEC-phase ALU settings.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_MEM_RD = 4'd4,
    ST_MEM_WR = 4'd5,
    ST_WB     = 4'd6,
    ST_BRANCH = 4'd7,
    ST_TRAP   = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_TIMEOUT = 2'd2
  } trap_cause_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1101;

  // ALU control for the compute phase. Only shifts-right carry IR[30] for
  // I-type, since for other I-type ops that bit is part of the immediate.
  function automatic logic [3:0] exec_alu_op(input logic [31:0] ir);
    logic [3:0] op;
    case (ir[6:0])
      OP_R:    op = {ir[30], ir[14:12]};
      OP_I:    op = {ir[30] & (ir[14:12] == F3_SR), ir[14:12]};
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // ALU B operand: register for R-type and branches, immediate otherwise.
  function automatic logic exec_src_b(input logic [31:0] ir);
    logic sel;
    case (ir[6:0])
      OP_R:    sel = 1'b0;
      OP_BR:   sel = 1'b0;
      default: sel = 1'b1;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/riscv_mem_watchdog.sv
// Memory wait watchdog: counts cycles spent waiting on a memory handshake
// and flags a timeout on the last permitted cycle.
// Ports: clock, rst (async, active-high); start clears the count; active marks
// a waiting cycle; ready is the memory handshake; timeout is asserted when the
// final allowed cycle passes without ready.
module riscv_mem_watchdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clock,
  input  logic rst,
  input  logic start,
  input  logic active,
  input  logic ready,
  output logic timeout
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] count;

  // Wait counter; never passes LAST because the timeout leaves the wait state.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (active && !ready) begin
      count <= count + CW'(1);
    end
  end

  // A ready on the final cycle wins over the timeout.
  assign timeout = active && !ready && (count == LAST);

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32 subset R/I-ALU, LW, SW, BEQ/BNE.
// Sequences FETCH/DECODE/EXEC/MEM/WB, latches the instruction register and
// drives every datapath select and strobe from the state and latched IR.
// Ports: clock, rst (async, active-high), run, instr, mem_ready, zero in;
// ir_write, pc_write, pc_src, reg_write, wb_sel, mem_read, mem_write,
// alu_src_b, alu_op, state_o (debug), trap/trap_cause (sticky), retired out.
module riscv_multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int XLEN        = 32
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            run,
  input  logic [31:0]     instr,
  input  logic            mem_ready,
  input  logic            zero,
  output logic            ir_write,
  output logic            pc_write,
  output logic            pc_src,
  output logic            reg_write,
  output logic            wb_sel,
  output logic            mem_read,
  output logic            mem_write,
  output logic            alu_src_b,
  output logic [3:0]      alu_op,
  output logic [3:0]      state_o,
  output logic            trap,
  output logic [1:0]      trap_cause,
  output logic [XLEN-1:0] retired
);

  state_t      state;
  state_t      state_next;
  logic [31:0] ir;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        wd_start;
  logic        wd_active;
  logic        wd_timeout;
  logic        retire;
  logic        trap_set;
  trap_cause_t cause_set;

  assign opcode  = ir[6:0];
  assign funct3  = ir[14:12];
  assign state_o = state;

  // The count restarts whenever the FSM changes state, which covers every
  // entry into FETCH/MEM_RD/MEM_WR including MEM_WR -> FETCH.
  assign wd_start = (state_next != state);

  riscv_mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clock  (clock),
    .rst    (rst),
    .start  (wd_start),
    .active (wd_active),
    .ready  (mem_ready),
    .timeout(wd_timeout)
  );

  // State register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Instruction register, loaded on the fetch handshake.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      ir <= 32'h0000_0000;
    end else if (ir_write) begin
      ir <= instr;
    end
  end

  // Sticky trap flag; the first recorded cause is kept.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      trap       <= 1'b0;
      trap_cause <= CAUSE_NONE;
    end else if (trap_set && !trap) begin
      trap       <= 1'b1;
      trap_cause <= cause_set;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      retired <= '0;
    end else if (retire) begin
      retired <= retired + XLEN'(1);
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_next = state;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = ALU_ADD;
    wd_active  = 1'b0;
    retire     = 1'b0;
    trap_set   = 1'b0;
    cause_set  = CAUSE_NONE;

    case (state)
      ST_IDLE: begin
        state_next = run ? ST_FETCH : ST_IDLE;
      end

      ST_FETCH: begin
        wd_active = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          state_next = ST_DECODE;
        end else if (wd_timeout) begin
          trap_set   = 1'b1;
          cause_set  = CAUSE_TIMEOUT;
          state_next = ST_TRAP;
        end else begin
          state_next = ST_FETCH;
        end
      end

      ST_DECODE: begin
        case (opcode)
          OP_R, OP_I, OP_LW, OP_SW: state_next = ST_EXEC;
          OP_BR: begin
            if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
              state_next = ST_BRANCH;
            end else begin
              trap_set   = 1'b1;
              cause_set  = CAUSE_ILLEGAL;
              state_next = ST_TRAP;
            end
          end
          default: begin
            trap_set   = 1'b1;
            cause_set  = CAUSE_ILLEGAL;
            state_next = ST_TRAP;
          end
        endcase
      end

      ST_EXEC: begin
        alu_src_b = exec_src_b(ir);
        alu_op    = exec_alu_op(ir);
        case (opcode)
          OP_LW:   state_next = ST_MEM_RD;
          OP_SW:   state_next = ST_MEM_WR;
          default: state_next = ST_WB;
        endcase
      end

      ST_MEM_RD: begin
        // Address selects stay put for the whole access.
        mem_read  = 1'b1;
        alu_src_b = 1'b1;
        wd_active = 1'b1;
        if (mem_ready) begin
          state_next = ST_WB;
        end else if (wd_timeout) begin
          trap_set   = 1'b1;
          cause_set  = CAUSE_TIMEOUT;
          state_next = ST_TRAP;
        end else begin
          state_next = ST_MEM_RD;
        end
      end

      ST_MEM_WR: begin
        mem_write = 1'b1;
        alu_src_b = 1'b1;
        wd_active = 1'b1;
        if (mem_ready) begin
          pc_write   = 1'b1;
          retire     = 1'b1;
          state_next = run ? ST_FETCH : ST_IDLE;
        end else if (wd_timeout) begin
          trap_set   = 1'b1;
          cause_set  = CAUSE_TIMEOUT;
          state_next = ST_TRAP;
        end else begin
          state_next = ST_MEM_WR;
        end
      end

      ST_WB: begin
        // ALU selects are held so an unregistered ALU result stays valid.
        alu_src_b  = exec_src_b(ir);
        alu_op     = exec_alu_op(ir);
        reg_write  = 1'b1;
        wb_sel     = (opcode == OP_LW);
        pc_write   = 1'b1;
        retire     = 1'b1;
        state_next = run ? ST_FETCH : ST_IDLE;
      end

      ST_BRANCH: begin
        alu_op     = ALU_SUB;
        pc_write   = 1'b1;
        pc_src     = (funct3 == F3_BEQ) ? zero : ~zero;
        retire     = 1'b1;
        state_next = run ? ST_FETCH : ST_IDLE;
      end

      ST_TRAP: begin
        state_next = ST_TRAP;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench for riscv_multicycle_ctrl. A driver issues directed and
// random instructions with chosen memory latencies and pushes the expected
// per-instruction outcome; a monitor accumulates what the DUT did over each
// instruction and compares when it retires or traps.
module tb_riscv_multicycle_ctrl;
  import riscv_ctrl_pkg::*;

  localparam int T       = 4;
  localparam int XW      = 4;
  localparam int N_ITEMS = 90;

  logic          clock;
  logic          rst;
  logic          run;
  logic [31:0]   instr;
  logic          mem_ready;
  logic          zero;
  logic          ir_write, pc_write, pc_src, reg_write, wb_sel;
  logic          mem_read, mem_write, alu_src_b;
  logic [3:0]    alu_op;
  logic [3:0]    state_o;
  logic          trap;
  logic [1:0]    trap_cause;
  logic [XW-1:0] retired;

  riscv_multicycle_ctrl #(.MEM_TIMEOUT(T), .XLEN(XW)) dut (
    .clock(clock), .rst(rst), .run(run), .instr(instr),
    .mem_ready(mem_ready), .zero(zero),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .wb_sel(wb_sel), .mem_read(mem_read),
    .mem_write(mem_write), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .state_o(state_o), .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    int          fd;    // extra fetch wait cycles before ready
    int          md;    // extra data wait cycles before ready
    logic        zero;
  } item_t;

  typedef struct {
    bit         trap;
    int         cause;
    int         cyc;
    int         ir;
    int         mr;
    int         mw;
    int         rw;
    logic [3:0] alu;
    logic       srcb;
    logic       pcsrc;
    logic       wb;
  } exp_t;

  exp_t q[$];
  bit   stim_done = 1'b0;
  int   total = 0;
  int   bad   = 0;

  wire [7:0] strobes = {ir_write, pc_write, pc_src, reg_write,
                        wb_sel, mem_read, mem_write, alu_src_b};

  // Reference model: outcome of one instruction from the ISA-level rules.
  function automatic exp_t model(input item_t it);
    exp_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    logic       b30;
    int         base;
    op  = it.instr[6:0];
    f3  = it.instr[14:12];
    b30 = it.instr[30];
    e   = '{trap: 1'b0, cause: 0, cyc: 0, ir: 1, mr: 0, mw: 0, rw: 0,
            alu: 4'd0, srcb: 1'b0, pcsrc: 1'b0, wb: 1'b0};
    if (it.fd >= T) begin
      e.trap = 1'b1; e.cause = 2; e.cyc = T; e.ir = 0;
      return e;
    end
    base = it.fd + 1;
    if (op == 7'b0110011) begin
      e.alu = {b30, f3}; e.srcb = 1'b0; e.rw = 1; e.cyc = base + 3;
    end else if (op == 7'b0010011) begin
      e.alu = {b30 & (f3 == 3'd5), f3}; e.srcb = 1'b1; e.rw = 1; e.cyc = base + 3;
    end else if (op == 7'b0000011) begin
      e.srcb = 1'b1;
      if (it.md >= T) begin
        e.trap = 1'b1; e.cause = 2; e.mr = T; e.cyc = base + 2 + T;
      end else begin
        e.mr = it.md + 1; e.rw = 1; e.wb = 1'b1; e.cyc = base + 2 + it.md + 2;
      end
    end else if (op == 7'b0100011) begin
      e.srcb = 1'b1;
      if (it.md >= T) begin
        e.trap = 1'b1; e.cause = 2; e.mw = T; e.cyc = base + 2 + T;
      end else begin
        e.mw = it.md + 1; e.cyc = base + 2 + it.md + 1;
      end
    end else if (op == 7'b1100011 && f3 <= 3'd1) begin
      e.alu = 4'b1000; e.srcb = 1'b0; e.cyc = base + 2;
      e.pcsrc = (f3 == 3'd0) ? it.zero : !it.zero;
    end else begin
      e.trap = 1'b1; e.cause = 1; e.cyc = base + 1;
    end
    return e;
  endfunction

  function automatic int rand_lat();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
  endfunction

  function automatic item_t next_item(input int n);
    item_t it;
    int    k;
    it.fd = 0; it.md = 0; it.zero = 1'b0;
    case (n)
      0:  it.instr = 32'h002081B3;                            // ADD x3,x1,x2
      1:  begin it.instr = 32'h0080A283; it.md = 3; end       // LW, ready after 3
      2:  begin it.instr = 32'h00208863; it.zero = 1'b1; end  // BEQ taken
      3:  begin it.instr = 32'h00208863; it.zero = 1'b0; end  // BEQ not taken
      4:  begin it.instr = 32'h00209863; it.zero = 1'b1; end  // BNE not taken
      5:  it.instr = 32'h40225213;                            // SRAI x4,x4,2
      6:  it.instr = 32'h40000093;                            // ADDI with IR[30]=1
      7:  begin it.instr = 32'h0020A223; it.md = 3; end       // SW, ready on 4th cycle
      8:  begin it.instr = 32'h0020A223; it.md = 9; end       // SW, memory stalls
      9:  it.instr = 32'h0000007F;                            // illegal opcode
      10: begin it.instr = 32'h002081B3; it.fd = 6; end       // fetch stalls
      default: begin
        it.instr = $urandom;
        it.fd    = rand_lat();
        it.md    = rand_lat();
        it.zero  = 1'($urandom_range(0, 1));
        k = $urandom_range(0, 9);
        if (k <= 1)      it.instr[6:0] = 7'b0110011;
        else if (k <= 3) it.instr[6:0] = 7'b0010011;
        else if (k == 4) it.instr[6:0] = 7'b0000011;
        else if (k == 5) it.instr[6:0] = 7'b0100011;
        else if (k <= 7) begin
          it.instr[6:0]   = 7'b1100011;
          it.instr[14:12] = 3'($urandom_range(0, 1));
        end else if (k == 8) begin
          it.instr[6:0] = 7'b1100011;
        end
      end
    endcase
    return it;
  endfunction

  // Driver: reacts to the DUT phase to time mem_ready, run and resets.
  initial begin : driver
    item_t  it;
    state_t st;
    state_t prev_st;
    int     wcnt, n, trap_wait, budget;
    bit     do_rst;
    rst = 1'b1; run = 1'b0; instr = 32'h0; mem_ready = 1'b0; zero = 1'b0;
    n = 0; wcnt = 0; trap_wait = 0; budget = 0;
    st = ST_IDLE; prev_st = ST_IDLE;
    it = next_item(0);
    repeat (3) @(posedge clock);
    #1 rst = 1'b0;
    while (!(n >= N_ITEMS && st == ST_IDLE) && budget < 20000) begin
      @(posedge clock);
      #1;
      budget++;
      do_rst    = 1'b0;
      st        = state_t'(state_o);
      wcnt      = (st == prev_st) ? wcnt + 1 : 0;
      trap_wait = (st == ST_TRAP) ? trap_wait + 1 : 0;
      mem_ready = 1'($urandom_range(0, 1));
      case (st)
        ST_FETCH: begin
          if (wcnt == 0) begin
            it    = next_item(n);
            n++;
            instr = it.instr;
            zero  = it.zero;
            q.push_back(model(it));
          end
          mem_ready = (wcnt == it.fd);
        end
        ST_MEM_RD: begin
          mem_ready = (wcnt == it.md);
          if (n > 11 && wcnt == 1 && $urandom_range(0, 14) == 0) do_rst = 1'b1;
        end
        ST_MEM_WR: mem_ready = (wcnt == it.md);
        ST_TRAP:   if (trap_wait >= 4) do_rst = 1'b1;
        default: ;
      endcase
      run = (n < N_ITEMS) ? ($urandom_range(0, 9) != 0) : 1'b0;
      if (do_rst) begin
        rst = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1 rst = 1'b0;
        st = ST_IDLE;
        wcnt = 0;
      end
      prev_st = st;
    end
    stim_done = 1'b1;
  end

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  int         cycles = 0, drain = 0, exp_ret = 0, hold_cause = 0;
  bit         in_instr = 1'b0, trap_seen = 1'b0;
  int         o_cyc, o_ir, o_mr, o_mw, o_rw;
  logic [3:0] o_alu;
  logic       o_srcb, o_wb;

  // Monitor: per-instruction observation and scoreboard compare.
  always @(negedge clock) begin : monitor
    state_t st;
    exp_t   e;
    cycles++;
    st = state_t'(state_o);
    if (rst) begin
      chk("rst_state", state_o, ST_IDLE);
      chk("rst_strobes", strobes, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_trap", trap, 0);
      chk("rst_cause", trap_cause, 0);
      chk("rst_retired", retired, 0);
      q.delete();
      in_instr = 1'b0; trap_seen = 1'b0; exp_ret = 0;
    end else if (st == ST_TRAP) begin
      if (!trap_seen) begin
        trap_seen = 1'b1;
        in_instr  = 1'b0;
        if (q.size() == 0) begin
          chk("trap_unexpected_q", 0, 1);
        end else begin
          e = q.pop_front();
          chk("trap_flag", trap, e.trap);
          chk("trap_cyc", o_cyc, e.cyc);
          chk("trap_ir_write", o_ir, e.ir);
          chk("trap_mem_read", o_mr, e.mr);
          chk("trap_mem_write", o_mw, e.mw);
          chk("trap_alu_op", o_alu, e.alu);
          chk("trap_alu_src_b", o_srcb, e.srcb);
          hold_cause = e.cause;
        end
      end
      chk("trap_cause", trap_cause, hold_cause);
      chk("trap_sticky", trap, 1);
      chk("trap_strobes", strobes, 0);
      chk("trap_retired", retired, exp_ret % 16);
    end else begin
      if (st == ST_FETCH && !in_instr) begin
        in_instr = 1'b1;
        o_cyc = 0; o_ir = 0; o_mr = 0; o_mw = 0; o_rw = 0;
        o_alu = 4'd0; o_srcb = 1'b0; o_wb = 1'b0;
      end
      if (in_instr) begin
        o_cyc++;
        if (ir_write)  o_ir++;
        if (mem_read)  o_mr++;
        if (mem_write) o_mw++;
        if (reg_write) begin o_rw++; o_wb = wb_sel; end
        if (st == ST_EXEC || st == ST_BRANCH) begin
          o_alu = alu_op; o_srcb = alu_src_b;
        end
        chk("retired", retired, exp_ret % 16);
        if (pc_write) begin
          in_instr = 1'b0;
          if (q.size() == 0) begin
            chk("retire_unexpected_q", 0, 1);
          end else begin
            e = q.pop_front();
            chk("retire_expected_trap", 0, e.trap);
            chk("cyc", o_cyc, e.cyc);
            chk("ir_write", o_ir, e.ir);
            chk("mem_read", o_mr, e.mr);
            chk("mem_write", o_mw, e.mw);
            chk("reg_write", o_rw, e.rw);
            chk("alu_op", o_alu, e.alu);
            chk("alu_src_b", o_srcb, e.srcb);
            chk("pc_src", pc_src, e.pcsrc);
            if (e.rw != 0) chk("wb_sel", o_wb, e.wb);
          end
          exp_ret++;
        end
      end else begin
        chk("idle_strobes", strobes, 0);
        chk("idle_retired", retired, exp_ret % 16);
      end
    end

    if (stim_done) begin
      if (q.size() == 0 && !in_instr) begin
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end else begin
        drain++;
        if (drain > 200) begin
          chk("drain_pending", q.size(), 0);
          $display("test done: total=%0d bad=%0d", total, bad);
          $finish;
        end
      end
    end else if (cycles > 60000) begin
      chk("cycle_budget", cycles, 60000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

endmodule
